reaction_judge: RTL and testbench
=================================

Name: reaction_judge

Overview:
- Parametrised round judge for the dexterity game.
- Each round it latches a target button index and a timeout window. It judges the first button press, or the window expiry, as correct, wrong or timeout, then maintains score and lives until game over.
- Sits between the random-number generator, the debounced/synchronised button bank and the display/score logic.
- Adds what the previous single-cycle comparator lacked:
  - press-edge detection;
  - per-round timeout;
  - lives;
  - speed-up mode.

Parameters:
- NUM_BUTTONS, 4, number of player buttons (2..16).
- IDX_W, $clog2(NUM_BUTTONS), width of the target index.
- SCORE_W, 8, score counter width.
- LIVES, 3, lives granted at game start (1..15).
- ROUND_TICKS, 1000, initial round window in tick pulses.
- MIN_TICKS, 200, floor of the round window in speed-up mode.
- SPEEDUP_STEP, 50, window reduction per correct round; 0 disables speed-up.
- TICK_W, 16, width of the window and countdown registers.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin new game; honoured only in IDLE or OVER.
- tick  in  1  timebase enable (e.g. 1 ms strobe); one countdown step per tick.
- target  in  IDX_W  random button index; sampled on new_round cycle.
- buttons  in  NUM_BUTTONS  synchronised, debounced button levels, 1 = pressed.
- new_round  out  1  one-cycle pulse: round armed, target latched, RNG may advance.
- round_active  out  1  high while in WAIT.
- correct  out  1  one-cycle pulse on correct press.
- wrong  out  1  one-cycle pulse on wrong press.
- timeout  out  1  one-cycle pulse on window expiry.
- score  out  SCORE_W  correct rounds this game.
- lives  out  4  remaining lives.
- game_over  out  1  high in OVER.

Behaviour:
- Reset values:
  - state = IDLE;
  - score = 0, lives = 0, all pulses 0, round_active = 0, game_over = 0;
  - window = ROUND_TICKS, countdown = 0, button history = 0.
- Edge detection:
  - rise = buttons & ~buttons_q;
  - buttons_q is registered every cycle in every state.
- States: IDLE, ARM, WAIT, RESULT, OVER.
- IDLE:
  - on start: score ← 0, lives ← LIVES, window ← ROUND_TICKS;
  - go to ARM.
- ARM:
  - waits until buttons == 0, which blocks held-button carry-over;
  - on that cycle: latch target, countdown ← window, new_round = 1;
  - go to WAIT.
- WAIT:
  - rise == one-hot(target_q): verdict CORRECT.
  - rise ≠ 0 otherwise (wrong bit, or multiple bits in the same cycle including the target): verdict WRONG.
  - rise == 0, tick = 1 and countdown == 1: verdict TIMEOUT.
  - Otherwise, on tick: countdown decrements.
  - A press in the same cycle as expiry wins, so it is judged, not timed out.
- RESULT (exactly one cycle):
  - the matching pulse is asserted;
  - CORRECT:
    - score ← score + 1, saturating at 2^SCORE_W − 1;
    - window ← max(window − SPEEDUP_STEP, MIN_TICKS), with no underflow.
  - WRONG or TIMEOUT: lives ← lives − 1 (lives never below 0).
  - Next state: OVER if the post-update lives == 0, else ARM.
- OVER:
  - game_over = 1; score and lives hold;
  - on start: behave as IDLE start.
- start is ignored in ARM, WAIT and RESULT.
- Latency: press edge in cycle n → pulse in cycle n+2 (registered rise judged in n+1, RESULT in n+2).
- Async reset mid-round aborts immediately, with no pulse emitted.
- target changes after new_round have no effect on the current round.

Decomposition:
- Shared package holds:
  - the state enum;
  - the verdict enum (NONE, CORRECT, WRONG, TIMEOUT);
  - LIVES_W = 4.
- One natural sub-module: press_edge.
  - Registers the button vector and outputs the rise mask.
  - Has its own clock and asynchronous active-high reset.

Test Plan (NUM_BUTTONS=4, LIVES=3, ROUND_TICKS=5, MIN_TICKS=3, SPEEDUP_STEP=1, tick held 1):
- Correct press:
  - stimulus: reset, start, target=2, rise on buttons=4'b0100 within the window;
  - required: correct pulse two cycles after the edge, score=1, lives=3, next round window=4.
- Wrong press:
  - stimulus: target=1, press 4'b1000;
  - required: one wrong pulse, lives 3→2, score unchanged, return to ARM.
- Multi-press and held button:
  - stimulus: press 4'b0110 with target=1;
  - required: wrong pulse.
  - stimulus: keep the buttons held;
  - required: ARM stalls, no new_round until buttons=0.
- Timeout and tie-break:
  - stimulus: no press;
  - required: timeout pulse after 5 ticks, lives −1.
  - stimulus: a correct edge on the expiry tick;
  - required: correct, not timeout.
- Game over and restart:
  - stimulus: three timeouts;
  - required: game_over=1, lives=0, start ignored mid-round.
  - stimulus: start in OVER;
  - required: score=0, lives=3, window=5.
- Speed-up floor, saturation and reset:
  - stimulus: 4 correct rounds;
  - required: window floors at 3.
  - stimulus: with SCORE_W=2, 5 correct rounds;
  - required: score=3.
  - stimulus: assert reset during WAIT;
  - required: outputs reach reset values immediately, no pulse.

Source files
------------

// File: rtl/reaction_judge_pkg.sv
// Shared types for the reaction judge: round FSM states and press verdicts.
package reaction_judge_pkg;

  localparam int LIVES_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    RESULT,
    OVER
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    CORRECT,
    WRONG,
    TIMEOUT
  } verdict_t;

endpackage

// File: rtl/press_edge.sv
// Registers the button bank and produces a registered rising-edge mask.
module press_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] buttons_q;

  // history register and registered rise mask, updated every cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buttons_q <= '0;
      rise      <= '0;
    end else begin
      buttons_q <= buttons;
      rise      <= buttons & ~buttons_q;
    end
  end

endmodule

// File: rtl/reaction_judge.sv
// Round judge: arms a round, judges the first press or window expiry,
// and tracks score, lives and the shrinking round window.
module reaction_judge
  import reaction_judge_pkg::*;
#(
  parameter int NUM_BUTTONS  = 4,
  parameter int IDX_W        = $clog2(NUM_BUTTONS),
  parameter int SCORE_W      = 8,
  parameter int LIVES        = 3,
  parameter int ROUND_TICKS  = 1000,
  parameter int MIN_TICKS    = 200,
  parameter int SPEEDUP_STEP = 50,
  parameter int TICK_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   tick,
  input  logic [IDX_W-1:0]       target,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   new_round,
  output logic                   round_active,
  output logic                   correct,
  output logic                   wrong,
  output logic                   timeout,
  output logic [SCORE_W-1:0]     score,
  output logic [LIVES_W-1:0]     lives,
  output logic                   game_over
);

  state_t                   state;
  state_t                   state_next;
  verdict_t                 judge;
  logic [NUM_BUTTONS-1:0]   rise;
  logic [NUM_BUTTONS-1:0]   target_mask;
  logic [IDX_W-1:0]         target_q;
  logic [TICK_W-1:0]        window;
  logic [TICK_W-1:0]        window_next;
  logic [TICK_W-1:0]        countdown;
  logic                     buttons_idle;

  press_edge #(.WIDTH(NUM_BUTTONS)) u_press_edge (
    .clock   (clock),
    .reset   (reset),
    .buttons (buttons),
    .rise    (rise)
  );

  assign buttons_idle = (buttons == '0);
  assign target_mask  = {{(NUM_BUTTONS-1){1'b0}}, 1'b1} << target_q;
  assign new_round    = (state == ARM) && buttons_idle;
  assign round_active = (state == WAIT);
  assign game_over    = (state == OVER);

  // verdict of the current WAIT cycle; a press beats a coincident expiry
  always_comb begin
    judge = NONE;
    if (rise == target_mask) begin
      judge = CORRECT;
    end else if (rise != '0) begin
      judge = WRONG;
    end else if (tick && (countdown <= TICK_W'(1))) begin
      judge = TIMEOUT;
    end else begin
      judge = NONE;
    end
  end

  // shrink the window after a correct round, clamped at the floor
  always_comb begin
    window_next = window;
    if (SPEEDUP_STEP == 0) begin
      window_next = window;
    end else if ({1'b0, window} >= (TICK_W+1)'(MIN_TICKS + SPEEDUP_STEP)) begin
      window_next = window - TICK_W'(SPEEDUP_STEP);
    end else begin
      window_next = TICK_W'(MIN_TICKS);
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ARM; else state_next = IDLE;
      ARM:     if (buttons_idle) state_next = WAIT; else state_next = ARM;
      WAIT:    if (judge != NONE) state_next = RESULT; else state_next = WAIT;
      RESULT:  if (lives == '0) state_next = OVER; else state_next = ARM;
      OVER:    if (start) state_next = ARM; else state_next = OVER;
      default: state_next = IDLE;
    endcase
  end

  // state register plus round, score and lives bookkeeping; pulses land in RESULT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      target_q  <= '0;
      window    <= TICK_W'(ROUND_TICKS);
      countdown <= '0;
      score     <= '0;
      lives     <= '0;
      correct   <= 1'b0;
      wrong     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state   <= state_next;
      correct <= 1'b0;
      wrong   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score  <= '0;
            lives  <= LIVES_W'(LIVES);
            window <= TICK_W'(ROUND_TICKS);
          end
        end
        ARM: begin
          if (buttons_idle) begin
            target_q  <= target;
            countdown <= window;
          end
        end
        WAIT: begin
          case (judge)
            CORRECT: begin
              correct <= 1'b1;
              window  <= window_next;
              if (score != '1) score <= score + SCORE_W'(1);
            end
            WRONG: begin
              wrong <= 1'b1;
              if (lives != '0) lives <= lives - LIVES_W'(1);
            end
            TIMEOUT: begin
              timeout <= 1'b1;
              if (lives != '0) lives <= lives - LIVES_W'(1);
            end
            NONE: begin
              if (tick && (countdown != '0)) countdown <= countdown - TICK_W'(1);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_judge.sv
// Directed bench for reaction_judge with a short window and a 2-bit score.
module tb_reaction_judge;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       tick;
  logic [1:0] target;
  logic [3:0] buttons;
  logic       new_round;
  logic       round_active;
  logic       correct;
  logic       wrong;
  logic       timeout;
  logic [1:0] score;
  logic [3:0] lives;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  reaction_judge #(
    .NUM_BUTTONS  (4),
    .IDX_W        (2),
    .SCORE_W      (2),
    .LIVES        (3),
    .ROUND_TICKS  (5),
    .MIN_TICKS    (3),
    .SPEEDUP_STEP (1),
    .TICK_W       (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .tick         (tick),
    .target       (target),
    .buttons      (buttons),
    .new_round    (new_round),
    .round_active (round_active),
    .correct      (correct),
    .wrong        (wrong),
    .timeout      (timeout),
    .score        (score),
    .lives        (lives),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_arm(input string tag);
    int k;
    k = 0;
    while (new_round !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    check({tag, "_new_round"}, 32'(new_round), 32'd1);
  endtask

  // press in the first WAIT cycle; verdict two cycles later
  task automatic press_round(input string tag, input logic [1:0] tgt, input logic [3:0] press,
                             input logic exp_c, input logic [3:0] exp_lives,
                             input logic [1:0] exp_score, input logic [15:0] exp_window,
                             input logic rel);
    wait_arm(tag);
    target = tgt;
    cyc();
    target = ~tgt;
    check({tag, "_active"}, 32'(round_active), 32'd1);
    buttons = press;
    cyc();
    check({tag, "_early"}, 32'({correct, wrong, timeout}), 32'd0);
    cyc();
    check({tag, "_correct"}, 32'(correct), 32'(exp_c));
    check({tag, "_wrong"}, 32'(wrong), 32'(!exp_c));
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_lives"}, 32'(lives), 32'(exp_lives));
    check({tag, "_score"}, 32'(score), 32'(exp_score));
    check({tag, "_window"}, 32'(dut.window), 32'(exp_window));
    if (rel) buttons = 4'b0000;
  endtask

  task automatic timeout_round(input string tag, input int w, input logic [3:0] exp_lives,
                               input logic hold_start);
    wait_arm(tag);
    target = 2'd0;
    cyc();
    if (hold_start) start = 1'b1;
    repeat (w - 1) cyc();
    check({tag, "_still_active"}, 32'(round_active), 32'd1);
    check({tag, "_no_early"}, 32'(timeout), 32'd0);
    start = 1'b0;
    cyc();
    check({tag, "_timeout"}, 32'(timeout), 32'd1);
    check({tag, "_no_correct"}, 32'(correct), 32'd0);
    check({tag, "_lives"}, 32'(lives), 32'(exp_lives));
  endtask

  // correct edge registered on the very cycle the window expires
  task automatic tie_round(input string tag, input logic [1:0] tgt, input int w,
                           input logic [1:0] exp_score, input logic [15:0] exp_window,
                           input logic [3:0] exp_lives);
    logic [3:0] one;
    wait_arm(tag);
    target = tgt;
    cyc();
    repeat (w - 2) cyc();
    one = 4'b0001;
    buttons = one << tgt;
    cyc();
    check({tag, "_early"}, 32'({correct, timeout}), 32'd0);
    cyc();
    check({tag, "_correct"}, 32'(correct), 32'd1);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_score"}, 32'(score), 32'(exp_score));
    check({tag, "_window"}, 32'(dut.window), 32'(exp_window));
    check({tag, "_lives"}, 32'(lives), 32'(exp_lives));
    buttons = 4'b0000;
  endtask

  initial begin
    logic [1:0]  g3_score [5];
    logic [15:0] g3_window [5];
    logic [3:0]  one;
    g3_score  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    g3_window = '{16'd4, 16'd3, 16'd3, 16'd3, 16'd3};

    reset = 1'b1; start = 1'b0; tick = 1'b1; target = 2'd0; buttons = 4'b0000;
    repeat (3) cyc();
    check("rst_score", 32'(score), 32'd0);
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_pulses", 32'({new_round, correct, wrong, timeout}), 32'd0);
    check("rst_active", 32'(round_active), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_window", 32'(dut.window), 32'd5);

    reset = 1'b0;
    cyc();
    check("idle_no_round", 32'(new_round), 32'd0);

    start = 1'b1; target = 2'd2;
    cyc();
    start = 1'b0;
    check("g1_lives", 32'(lives), 32'd3);
    check("g1_score", 32'(score), 32'd0);

    press_round("r1_correct", 2'd2, 4'b0100, 1'b1, 4'd3, 2'd1, 16'd4, 1'b1);
    press_round("r2_wrong",   2'd1, 4'b1000, 1'b0, 4'd2, 2'd1, 16'd4, 1'b1);
    press_round("r3_multi",   2'd1, 4'b0110, 1'b0, 4'd1, 2'd1, 16'd4, 1'b0);

    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("held_stall%0d", i), 32'({new_round, round_active}), 32'd0);
    end
    buttons = 4'b0000;
    #1;
    check("held_release", 32'(new_round), 32'd1);

    tie_round("r4_tie", 2'd3, 4, 2'd2, 16'd3, 4'd1);
    timeout_round("r5_to", 3, 4'd0, 1'b1);

    cyc();
    check("g1_over", 32'(game_over), 32'd1);
    check("g1_over_lives", 32'(lives), 32'd0);
    check("g1_over_score", 32'(score), 32'd2);
    check("g1_over_idle", 32'({new_round, round_active}), 32'd0);
    cyc();
    check("g1_over_hold", 32'(game_over), 32'd1);

    start = 1'b1;
    cyc();
    start = 1'b0;
    check("g2_score", 32'(score), 32'd0);
    check("g2_lives", 32'(lives), 32'd3);
    check("g2_window", 32'(dut.window), 32'd5);
    check("g2_not_over", 32'(game_over), 32'd0);

    timeout_round("g2_t1", 5, 4'd2, 1'b0);
    timeout_round("g2_t2", 5, 4'd1, 1'b0);
    timeout_round("g2_t3", 5, 4'd0, 1'b0);
    cyc();
    check("g2_over", 32'(game_over), 32'd1);
    check("g2_over_lives", 32'(lives), 32'd0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    one = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      press_round($sformatf("g3_r%0d", i), 2'(i), one << 2'(i), 1'b1, 4'd3,
                  g3_score[i], g3_window[i], 1'b1);
    end

    wait_arm("rst_mid");
    target = 2'd1;
    cyc();
    buttons = 4'b0010;
    cyc();
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_pulses", 32'({correct, wrong, timeout, new_round}), 32'd0);
    check("rst_mid_active", 32'(round_active), 32'd0);
    check("rst_mid_score", 32'(score), 32'd0);
    check("rst_mid_lives", 32'(lives), 32'd0);
    check("rst_mid_over", 32'(game_over), 32'd0);
    cyc();
    check("rst_mid_quiet", 32'({correct, wrong, timeout}), 32'd0);
    reset = 1'b0;
    buttons = 4'b0000;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
